// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serializes fetch (read-only) and memory-stage (read/write)
// accesses onto one single-port RAM. Ties are broken round-robin, and reads
// wait a fixed READ_LAT cycles for RAM data.
//   clk, reset_n                     clock, async active-low reset
//   if_req/if_addr                   fetch request in
//   if_gnt/if_rvalid/if_rdata        fetch grant and read response out
//   mem_req/mem_we/mem_addr/mem_wdata memory-stage request in
//   mem_gnt/mem_rvalid/mem_rdata     memory-stage grant and read response out
//   ram_en/ram_we/ram_addr/ram_wdata RAM command out
//   ram_rdata                        RAM read data in
//   busy                             high while a transaction is outstanding
module ram_port_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_gnt,
   output logic              mem_rvalid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state, state_nx;
   logic       last;
   logic [3:0] cnt;
   logic       sel, pick_mem, done;
   // last doubles as the owner of the transaction in flight (1 = memory stage)
   always_comb begin
      sel      = (state == IDLE) && (if_req || mem_req);
      pick_mem = mem_req && (!if_req || !last);
      done     = (state == WAIT) && (cnt == 4'd0);
      // ram_we still holds the issued command while in ISSUE
      state_nx = sel ? ISSUE :
                 (state == ISSUE) ? (ram_we ? IDLE : WAIT) :
                 done ? IDLE : state;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last       <= 1'b0;
         cnt        <= 4'd0;
         if_gnt     <= 1'b0;
         mem_gnt    <= 1'b0;
         if_rvalid  <= 1'b0;
         mem_rvalid <= 1'b0;
         if_rdata   <= '0;
         mem_rdata  <= '0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         if_gnt     <= sel && !pick_mem;
         mem_gnt    <= sel && pick_mem;
         ram_en     <= sel;
         ram_we     <= sel && pick_mem && mem_we;
         if (sel) begin
            ram_addr  <= pick_mem ? mem_addr : if_addr;
            ram_wdata <= pick_mem ? mem_wdata : '0;
            last      <= pick_mem;
         end
         if (state == ISSUE)
            cnt <= 4'(READ_LAT - 1);
         else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
         if_rvalid  <= done && !last;
         mem_rvalid <= done && last;
         if (done && !last)
            if_rdata <= ram_rdata;
         if (done && last)
            mem_rdata <= ram_rdata;
         busy <= state_nx != IDLE;
      end
   end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of ram_port_arbiter with READ_LAT=2 (d0) and READ_LAT=1 (d1).
module tb_ram_port_arbiter;
   localparam int AW = 16;
   localparam int DW = 32;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   logic          if_req, mem_req, mem_we;
   logic [AW-1:0] if_addr, mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_en, ram_we, busy;
   logic [DW-1:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic          q_if_req, q_mem_req, q_mem_we;
   logic [AW-1:0] q_if_addr, q_mem_addr;
   logic [DW-1:0] q_mem_wdata;
   logic          q_if_gnt, q_if_rvalid, q_mem_gnt, q_mem_rvalid, q_ram_en, q_ram_we, q_busy;
   logic [DW-1:0] q_if_rdata, q_mem_rdata, q_ram_wdata, q_ram_rdata;
   logic [AW-1:0] q_ram_addr;
   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) d0 (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );
   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) d1 (
      .clk(clk), .reset_n(reset_n),
      .if_req(q_if_req), .if_addr(q_if_addr), .if_gnt(q_if_gnt), .if_rvalid(q_if_rvalid), .if_rdata(q_if_rdata),
      .mem_req(q_mem_req), .mem_we(q_mem_we), .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata),
      .mem_gnt(q_mem_gnt), .mem_rvalid(q_mem_rvalid), .mem_rdata(q_mem_rdata),
      .ram_en(q_ram_en), .ram_we(q_ram_we), .ram_addr(q_ram_addr), .ram_wdata(q_ram_wdata),
      .ram_rdata(q_ram_rdata), .busy(q_busy)
   );
   // RAM model: one written word over a fixed preload, with a read pipeline per DUT
   logic          wv = 1'b0;
   logic [7:0]    wa = 8'h0;
   logic [DW-1:0] wd = '0;
   logic [DW-1:0] p0, p1, q0;
   function automatic logic [DW-1:0] rd(input logic [7:0] a);
      return (wv && a == wa) ? wd : (a == 8'h10) ? 32'hDEADBEEF : {24'hC0DE00, a};
   endfunction
   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         wv <= 1'b1;
         wa <= ram_addr[7:0];
         wd <= ram_wdata;
      end
      p0 <= (ram_en && !ram_we) ? rd(ram_addr[7:0]) : 32'hBAD0BAD0;
      p1 <= p0;
      q0 <= (q_ram_en && !q_ram_we) ? rd(q_ram_addr[7:0]) : 32'hBAD0BAD0;
   end
   assign ram_rdata   = p1;
   assign q_ram_rdata = q0;
   int n_cmp = 0;
   int n_bad = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   int       gcnt, last_g, ifrv, memrv, nrv;
   logic     raise;
   logic [3:0] order;
   logic [31:0] rl1_exp [3];
   initial begin
      rl1_exp = '{32'hDEADBEEF, 32'hC0DE0011, 32'hC0DE0012};
      if_req = 0; mem_req = 0; mem_we = 0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
      q_if_req = 0; q_mem_req = 0; q_mem_we = 0; q_if_addr = '0; q_mem_addr = '0; q_mem_wdata = '0;
      repeat (2) tick();
      check("rst_busy", busy, 0);
      check("rst_en", ram_en, 0);
      check("rst_gnt", {if_gnt, mem_gnt}, 0);
      check("rst_rdata", if_rdata, 0);
      reset_n = 1;
      tick();
      check("idle_busy", busy, 0);
      // fetch read of 0x0010
      if_addr = 16'h0010; if_req = 1;
      tick();
      check("if_gnt", if_gnt, 1);
      check("if_en", ram_en, 1);
      check("if_we", ram_we, 0);
      check("if_addr", ram_addr, 16'h0010);
      check("if_busy1", busy, 1);
      check("if_nomemgnt", mem_gnt, 0);
      if_req = 0;
      tick();
      check("if_gnt_pulse", if_gnt, 0);
      check("if_en_pulse", ram_en, 0);
      check("if_busy2", busy, 1);
      check("if_addr_hold", ram_addr, 16'h0010);
      tick();
      check("if_busy3", busy, 1);
      check("if_early_rv", if_rvalid, 0);
      tick();
      check("if_rvalid", if_rvalid, 1);
      check("if_rdata", if_rdata, 32'hDEADBEEF);
      check("if_busy4", busy, 0);
      check("if_no_memrv", mem_rvalid, 0);
      tick();
      check("if_rv_pulse", if_rvalid, 0);
      check("if_rdata_hold", if_rdata, 32'hDEADBEEF);
      // memory write, then a fetch request raised only across the ISSUE edge
      mem_req = 1; mem_we = 1; mem_addr = 16'h0200; mem_wdata = 32'h12345678;
      tick();
      check("wr_gnt", mem_gnt, 1);
      check("wr_ifgnt", if_gnt, 0);
      check("wr_en", ram_en, 1);
      check("wr_we", ram_we, 1);
      check("wr_addr", ram_addr, 16'h0200);
      check("wr_wdata", ram_wdata, 32'h12345678);
      mem_req = 0; mem_we = 0; mem_addr = 16'hFFFF; mem_wdata = '0;
      if_req = 1; if_addr = 16'h0033;
      tick();
      check("wr_busy", busy, 0);
      check("wr_en_off", ram_en, 0);
      check("wr_we_off", ram_we, 0);
      check("wr_addr_hold", ram_addr, 16'h0200);
      if_req = 0;
      tick();
      check("drop_no_gnt", if_gnt, 0);
      check("drop_no_en", ram_en, 0);
      repeat (3) begin
         check("wr_no_rv", mem_rvalid, 0);
         tick();
      end
      // memory read aborted by reset in WAIT
      mem_req = 1; mem_we = 0; mem_addr = 16'h0210;
      tick();
      check("mrd_gnt", mem_gnt, 1);
      check("mrd_we", ram_we, 0);
      check("mrd_addr", ram_addr, 16'h0210);
      mem_req = 0;
      tick();
      check("mrd_busy", busy, 1);
      #2 reset_n = 0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_addr", ram_addr, 0);
      check("arst_wdata", ram_wdata, 0);
      check("arst_ifrdata", if_rdata, 0);
      tick();
      tick();
      reset_n = 1;
      repeat (4) begin
         tick();
         check("abort_no_rv", mem_rvalid, 0);
         check("abort_rdata", mem_rdata, 0);
      end
      // tie with both requests held: mem, IF, mem, IF
      if_addr = 16'h0010; mem_addr = 16'h0200; mem_we = 0;
      if_req = 1; mem_req = 1;
      gcnt = 0; last_g = 0; ifrv = 0; memrv = 0; order = '0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (if_gnt || mem_gnt) begin
            check("tie_one_gnt", if_gnt & mem_gnt, 0);
            if (gcnt < 4) order[gcnt] = mem_gnt;
            if (gcnt > 0) check("tie_spacing", c - last_g, 4);
            last_g = c;
            gcnt++;
            if (gcnt == 4) begin
               if_req = 0;
               mem_req = 0;
            end
         end
         if (if_rvalid) begin
            check("tie_if_data", if_rdata, 32'hDEADBEEF);
            ifrv++;
         end
         if (mem_rvalid) begin
            check("tie_mem_data", mem_rdata, 32'h12345678);
            memrv++;
         end
      end
      check("tie_grants", gcnt, 4);
      check("tie_order", order, 4'b0101);
      check("tie_ifrv", ifrv, 2);
      check("tie_memrv", memrv, 2);
      // READ_LAT=1 back-to-back fetches, re-requested the cycle after rvalid
      q_if_addr = 16'h0010; q_if_req = 1;
      gcnt = 0; last_g = 0; nrv = 0; raise = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (raise) begin
            q_if_req = 1;
            raise = 0;
         end
         if (q_if_gnt) begin
            if (gcnt > 0) check("rl1_spacing", c - last_g, 4);
            last_g = c;
            gcnt++;
            q_if_req = 0;
         end
         if (q_if_rvalid) begin
            check("rl1_rv_lat", c - last_g, 2);
            if (nrv < 3) check("rl1_data", q_if_rdata, rl1_exp[nrv]);
            nrv++;
            if (nrv < 3) begin
               q_if_addr = q_if_addr + 16'h1;
               raise = 1;
            end
         end
      end
      check("rl1_count", nrv, 3);
      check("rl1_memrv", q_mem_rvalid, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
